// File: rtl/normalizador.sv
// Post-adder normalizer and rounder: shifts the raw mantissa sum one bit per cycle,
// rounds to nearest-even and packs an IEEE-754 single-precision result.
module normalizador (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        Signo,
    input  logic [26:0] Mantissa_Suma,
    input  logic [7:0]  Exp_comun,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Resultado,
    output logic        Overflow,
    output logic        Underflow
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [26:0] m_q, m_d;
    logic [8:0]  e_q, e_d;
    logic [31:0] res_q, res_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic        round_up;
    logic [24:0] sig_rnd;
    logic [22:0] sig_fin;
    logic [8:0]  e_rnd;

    // Rounding datapath; the 25-bit sum exposes the carry that renormalizes by one.
    assign round_up = m_q[1] & (m_q[0] | m_q[2]);
    assign sig_rnd  = {1'b0, m_q[25:2]} + {24'd0, round_up};
    assign sig_fin  = sig_rnd[24] ? sig_rnd[23:1] : sig_rnd[22:0];
    assign e_rnd    = sig_rnd[24] ? (e_q + 9'd1) : e_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            m_q     <= '0;
            e_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            m_q     <= m_d;
            e_q     <= e_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        m_d     = m_q;
        e_d     = e_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = Signo;
                    m_d     = Mantissa_Suma;
                    e_d     = {1'b0, Exp_comun};
                    state_d = NORM;
                end
            end

            // Rule order matters: carry beats normalized, normalized beats flush.
            NORM: begin
                if (m_q == 27'd0) begin
                    res_d   = {sign_q, 31'd0};
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = DONE;
                end else if (m_q[26]) begin
                    m_d = {1'b0, m_q[26:2], m_q[1] | m_q[0]};
                    e_d = e_q + 9'd1;
                end else if (m_q[25]) begin
                    state_d = ROUND;
                end else if (e_q <= 9'd1) begin
                    res_d   = {sign_q, 31'd0};
                    ovf_d   = 1'b0;
                    unf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    m_d = {m_q[25:0], 1'b0};
                    e_d = e_q - 9'd1;
                end
            end

            ROUND: begin
                if (e_rnd >= 9'd255) begin
                    res_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d = 1'b1;
                end else begin
                    res_d = {sign_q, e_rnd[7:0], sig_fin};
                    ovf_d = 1'b0;
                end
                unf_d   = 1'b0;
                state_d = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Resultado = res_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule

// File: doc/normalizador.md
# normalizador

Post-adder normalizer and rounder for the single-precision floating-point adder. It accepts the raw 27-bit mantissa sum, the common biased exponent and the result sign produced downstream of mantissa alignment. It then iteratively normalizes the sum (one shift per cycle), rounds to nearest-even and packs an IEEE-754 single-precision word. It is the inverse step of exponent alignment and sits between the mantissa adder/subtractor and the result register, using a valid/ready handshake on both sides.

## Interface

Parameters: none (format fixed to IEEE-754 single precision).

- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream operands valid
- in_ready  output  1  block can accept operands; high only in IDLE
- Signo  input  1  sign of the result
- Mantissa_Suma  input  27  bit 26 = carry-out, bits 25:2 = significand (bit 25 = hidden one), bit 1 = guard, bit 0 = sticky
- Exp_comun  input  8  common biased exponent
- out_valid  output  1  Resultado and flags valid; held until accepted
- out_ready  input  1  downstream accepts result
- Resultado  output  32  packed result {sign, exp[7:0], frac[22:0]}
- Overflow  output  1  result saturated to infinity
- Underflow  output  1  result flushed to zero

## Operation

- **FSM states:** IDLE, NORM, ROUND, DONE. Reset forces IDLE.
- **IDLE:**
  - in_ready=1.
  - On in_valid: latch sign, the mantissa into a 27-bit register M, and {1'b0,Exp_comun} into a 9-bit register E.
  - Next state NORM.
- **NORM:** evaluated once per cycle, first matching rule applies.
  - M==0: result = {Signo,31'b0}, no flags, go to DONE.
  - M[26]==1: right shift M = {1'b0, M[26:2], M[1]|M[0]} (sticky preserved), E=E+1, stay in NORM.
  - M[25]==1: go to ROUND.
  - E<=1: flush. Result = {Signo,31'b0}, Underflow=1, go to DONE.
  - Otherwise: left shift M<<1 (zero fill), E=E-1, stay in NORM. At most 25 left shifts.
- **ROUND:**
  - Round up if M[1] & (M[0] | M[2]), i.e. round to nearest, ties to even.
  - Significand S = M[25:2] + roundup, computed at 25 bits.
  - If S[24]==1 (rounding carry): S = S>>1, E = E+1.
  - If E>=255: Resultado = {Signo,8'hFF,23'b0}, Overflow=1.
  - Otherwise: Resultado = {Signo, E[7:0], S[22:0]}.
  - Go to DONE.
- **DONE:**
  - out_valid=1. Resultado and flags are stable.
  - When out_ready=1, go to IDLE; out_valid drops the next cycle.
- Exp_comun=255 at input is not treated as NaN/Inf. It follows normal flow and ends in Overflow.
- Flags and Resultado are registered; they update only on entry to DONE.

## Timing

- **Reset values:** state IDLE, in_ready=1, out_valid=0, Resultado=32'h0, Overflow=0, Underflow=0.
- **Accept** occurs on the edge where in_valid & in_ready are both high (edge A).
- **Latency** to out_valid high, counted in edges after A:
  - 1 for a zero sum.
  - n+2 for n shifts (right carry shift counts as 1).
  - Flush: edge at which the E<=1 rule fires.
  - Maximum 27.
- **Back-to-back:** earliest next accept is the edge after the DONE handshake. Throughput is one result per latency+2 cycles.
- **Input changes:** the block ignores in_valid and input changes outside IDLE.
- **Output backpressure:** out_ready is ignored outside DONE. Outputs are held indefinitely while out_ready=0.
- **Reset mid-operation:** rst asserted in any state immediately returns to reset values. The in-flight operand is discarded and no partial result is emitted.

## Test plan

- 1.0+1.0: Mantissa_Suma=27'h4000000, Exp_comun=127, Signo=0 → Resultado=32'h40000000, flags 0, out_valid 3 edges after accept.
- Cancellation: Mantissa_Suma=27'h0000004, Exp_comun=127 → 23 left shifts, Resultado=32'h34000000, out_valid 25 edges after accept. Also zero sum Mantissa_Suma=0 → 32'h00000000 after 1 edge.
- Rounding:
  - M[25:2] all ones, guard=1, Exp_comun=127, Signo=1 → rounding carry, Resultado=32'hC0000000.
  - Tie case M=27'h2000002 → no round-up (even), Resultado=32'h3F800000.
- Overflow/underflow:
  - M=27'h4000000, Exp_comun=254 → 32'h7F800000, Overflow=1.
  - M=27'h1000000, Exp_comun=1 → 32'h00000000, Underflow=1.
- Handshake: hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0 throughout. Assert rst mid-NORM → out_valid stays 0, in_ready=1 immediately, and the next operand completes correctly.
